// File: rtl/keypad_scan16.sv
// ============================================================================
// keypad_scan16
// ----------------------------------------------------------------------------
// Scans a 4x4 hex matrix keypad and collects accepted keys into a 32-bit
// shift register that can drive an 8-digit 7-segment display directly.
//
// One row is driven low at a time. The active-low columns are synchronized
// and sampled once per scan tick. A press must look identical for
// DEBOUNCE_TICKS consecutive samples before it is accepted. A release must
// read idle for DEBOUNCE_TICKS consecutive samples before scanning resumes.
// Holding a key down never produces a repeat.
//
// Parameters
//   DIV_W          prescaler width; one scan tick every 2**DIV_W clk cycles
//   DEBOUNCE_TICKS consecutive identical samples to accept press/release (>=2)
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high reset
//   i_col        in   4   keypad columns, active low, asynchronous to clk
//   i_clear      in   1   synchronous clear of o_data
//   o_row        out  4   row drive, active-low one-hot
//   o_key        out  4   last accepted key code ({row, col})
//   o_key_valid  out  1   one-clk pulse per accepted key
//   o_data       out  32  last 8 keys, newest in [3:0]
// ============================================================================
module keypad_scan16 #(
    parameter int DIV_W          = 15,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  i_col,
    input  logic        i_clear,
    output logic [3:0]  o_row,
    output logic [3:0]  o_key,
    output logic        o_key_valid,
    output logic [31:0] o_data
);

    // Counter must be able to hold DEBOUNCE_TICKS itself.
    localparam int                CNT_W      = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_presc;
    logic             w_tick;

    logic [3:0]       r_col_meta;
    logic [3:0]       r_col_s;
    logic [3:0]       w_col_low;
    logic             w_col_valid;
    logic             w_col_idle;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_row;
    logic [1:0]       w_row_next;
    logic [1:0]       r_cap_row;
    logic [1:0]       w_cap_row_next;
    logic [3:0]       r_cap_col;
    logic [3:0]       w_cap_col_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;

    logic [3:0]       w_cap_col_low;
    logic [1:0]       w_cap_col_idx;
    logic [3:0]       w_code;
    logic             w_accept;

    logic [3:0]       r_key;
    logic             r_key_valid;
    logic [31:0]      r_data;

    // ------------------------------------------------------------------
    // Prescaler: free-running, tick on the all-ones count
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + DIV_W'(1);
        end
    end

    assign w_tick = &r_presc;

    // ------------------------------------------------------------------
    // Column synchronizer, one 2-FF chain per column line.
    // Resets to all-high so the first samples read as idle.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_col_meta[gi] <= 1'b1;
                    r_col_s[gi]    <= 1'b1;
                end else begin
                    r_col_meta[gi] <= i_col[gi];
                    r_col_s[gi]    <= r_col_meta[gi];
                end
            end
        end
    endgenerate

    // Exactly one column low: non-zero and a power of two after inversion.
    assign w_col_low   = ~r_col_s;
    assign w_col_idle  = (r_col_s == 4'hF);
    assign w_col_valid = (w_col_low != 4'h0) &&
                         ((w_col_low & (w_col_low - 4'd1)) == 4'h0);

    // The captured column is guaranteed one-hot-low, so a plain OR
    // encoder is enough to recover its index.
    assign w_cap_col_low    = ~r_cap_col;
    assign w_cap_col_idx[0] = w_cap_col_low[1] | w_cap_col_low[3];
    assign w_cap_col_idx[1] = w_cap_col_low[2] | w_cap_col_low[3];
    assign w_code           = {r_cap_row, w_cap_col_idx};

    assign w_cnt_inc = r_cnt + CNT_ONE;

    // ------------------------------------------------------------------
    // Scan / debounce FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_SCAN;
            r_row     <= 2'd0;
            r_cap_row <= 2'd0;
            r_cap_col <= 4'hF;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_row     <= w_row_next;
            r_cap_row <= w_cap_row_next;
            r_cap_col <= w_cap_col_next;
            r_cnt     <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Scan / debounce FSM: next state. Nothing moves between ticks, and
    // the row index only advances from SCAN or when leaving DEBOUNCE/HELD,
    // which is what keeps the row frozen while a key is being examined.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_row_next     = r_row;
        w_cap_row_next = r_cap_row;
        w_cap_col_next = r_cap_col;
        w_cnt_next     = r_cnt;
        w_accept       = 1'b0;

        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_col_valid) begin
                        // First matching sample already counts as one.
                        w_cap_row_next = r_row;
                        w_cap_col_next = r_col_s;
                        w_cnt_next     = CNT_ONE;
                        w_state_next   = ST_DEBOUNCE;
                    end else begin
                        w_row_next = r_row + 2'd1;
                    end
                end

                ST_DEBOUNCE: begin
                    if (r_col_s == r_cap_col) begin
                        if (w_cnt_inc == CNT_TARGET) begin
                            w_accept     = 1'b1;
                            w_cnt_next   = '0;
                            w_state_next = ST_HELD;
                        end else begin
                            w_cnt_next = w_cnt_inc;
                        end
                    end else begin
                        // Bounce, early release or a second key: drop it.
                        w_cnt_next   = '0;
                        w_row_next   = r_row + 2'd1;
                        w_state_next = ST_SCAN;
                    end
                end

                ST_HELD: begin
                    if (w_col_idle) begin
                        if (w_cnt_inc == CNT_TARGET) begin
                            w_cnt_next   = '0;
                            w_row_next   = r_row + 2'd1;
                            w_state_next = ST_SCAN;
                        end else begin
                            w_cnt_next = w_cnt_inc;
                        end
                    end else begin
                        // Any low column restarts the release count.
                        w_cnt_next = '0;
                    end
                end

                default: begin
                    w_cnt_next   = '0;
                    w_state_next = ST_SCAN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output registers. An accept coinciding with i_clear leaves only the
    // new key in the shift register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
            r_data      <= 32'h0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key <= w_code;
            end
            if (w_accept && i_clear) begin
                r_data <= {28'h0, w_code};
            end else if (w_accept) begin
                r_data <= {r_data[27:0], w_code};
            end else if (i_clear) begin
                r_data <= 32'h0;
            end
        end
    end

    assign o_row       = ~(4'b0001 << r_row);
    assign o_key       = r_key;
    assign o_key_valid = r_key_valid;
    assign o_data      = r_data;

endmodule

// File: tb/tb_keypad_scan16.sv
`timescale 1ns/1ps
module tb_keypad_scan16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  i_col;
    logic        i_clear;
    logic [3:0]  o_row;
    logic [3:0]  o_key;
    logic        o_key_valid;
    logic [31:0] o_data;

    keypad_scan16 #(
        .DIV_W          (2),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_col       (i_col),
        .i_clear     (i_clear),
        .o_row       (o_row),
        .o_key       (o_key),
        .o_key_valid (o_key_valid),
        .o_data      (o_data)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column.
    logic [15:0] keys_down;
    always_comb begin
        i_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_down[4*r+c] && !o_row[r]) i_col[c] = 1'b0;
    end

    // Scoreboard
    typedef struct packed {
        logic [3:0]  key;
        logic [31:0] data;
    } exp_t;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model_data;
    int          checks = 0;
    int          passes = 0;
    int          accept_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Reference: each accepted key shifts into an 8-nibble history;
    // a coincident clear leaves only the new key.
    task automatic push_exp(input logic [3:0] k, input bit clr);
        exp_t e;
        if (clr) model_data = {28'h0, k};
        else     model_data = {model_data[27:0], k};
        e.key  = k;
        e.data = model_data;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every pulse against the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && o_key_valid === 1'b1) begin
            accept_count++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pulse: key %h data %h, required no pulse", o_key, o_data);
            end else begin
                mon_e = exp_q.pop_front();
                $display("accept key=%h data=%h (expected key=%h data=%h)",
                         o_key, o_data, mon_e.key, mon_e.data);
                check("key", {28'h0, o_key}, {28'h0, mon_e.key});
                check("data", o_data, mon_e.data);
            end
        end
    end

    // Wait (bounded) until the monitor has consumed all expectations.
    task automatic wait_accept();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) begin
            checks++;
            $display("FAIL accept_timeout: %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic row_of(input logic [3:0] k, output logic [3:0] row);
        row = ~(4'b0001 << k[3:2]);
    endtask

    task automatic press_key(input logic [3:0] k, input int hold, input bit clr);
        logic [3:0] er;
        row_of(k, er);
        push_exp(k, clr);
        keys_down[k] = 1'b1;
        if (clr) i_clear = 1'b1;
        wait_accept();
        i_clear = 1'b0;
        check("row_frozen", {28'h0, o_row}, {28'h0, er});
        repeat (hold) @(negedge clk);
        #1;
        check("row_held", {28'h0, o_row}, {28'h0, er});
        keys_down[k] = 1'b0;
        repeat (24) @(negedge clk);
        #1;
    endtask

    task automatic wait_row(input logic [3:0] er);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (o_row == er) seen = 1;
            else begin @(negedge clk); #1; end
        end
        if (!seen) begin
            checks++;
            $display("FAIL row_timeout: row %b, required %b", o_row, er);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] prev_row, er, kk, seq[4];
        int         nchg, last_idx, base, rr;

        seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
        keys_down  = 16'h0;
        i_clear    = 1'b0;
        model_data = 32'h0;

        // 1. Reset and idle rotation
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_row",   {28'h0, o_row},   32'he);
        check("rst_data",  o_data,           32'h0);
        check("rst_valid", {31'h0, o_key_valid}, 32'h0);
        check("rst_key",   {28'h0, o_key},   32'h0);
        @(negedge clk); #1;
        reset = 1'b0;
        prev_row = o_row;
        nchg = 0; last_idx = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk); #1;
            if (o_row != prev_row) begin
                if (nchg < 4) check("rot_value", {28'h0, o_row}, {28'h0, seq[nchg]});
                if (last_idx >= 0) check("rot_period", i - last_idx, 4);
                last_idx = i;
                nchg++;
                prev_row = o_row;
            end
        end
        check("rot_steps", (nchg >= 4) ? 1 : 0, 1);

        // 2. Row 2 / col 1 held for 40 clk
        press_key(4'h9, 40, 0);
        check("key9_data", o_data, 32'h9);

        // 5. Clear alone, then clear coinciding with an accept
        i_clear = 1'b1;
        @(negedge clk); #1;
        i_clear = 1'b0;
        model_data = 32'h0;
        check("clr_data", o_data, 32'h0);
        check("clr_key", {28'h0, o_key}, 32'h9);
        press_key(4'h1, 3, 0);
        press_key(4'h2, 3, 0);
        check("pre_clr_data", o_data, 32'h12);
        press_key(4'hA, 5, 1);
        check("clr_accept_data", o_data, 32'hA);

        // 3. Keys 1..9
        base = accept_count;
        for (int k = 1; k <= 9; k++) press_key(4'(k), $urandom_range(0, 10), 0);
        check("seq_data", o_data, 32'h23456789);
        check("seq_pulses", accept_count - base, 9);

        // 4a. Bounce: low for one tick, high, then stable
        kk = 4'($urandom_range(0, 15));
        row_of(kk, er);
        wait_row(er);
        keys_down[kk] = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        keys_down[kk] = 1'b0;
        repeat ($urandom_range(4, 8)) @(negedge clk);
        #1;
        press_key(kk, 6, 0);

        // 4b. Two columns low in one row: no accept, scanning continues
        rr = $urandom_range(0, 3);
        keys_down[4*rr+1] = 1'b1;
        keys_down[4*rr+2] = 1'b1;
        base = accept_count;
        prev_row = o_row;
        nchg = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (o_row != prev_row) begin nchg++; prev_row = o_row; end
        end
        check("twocol_rotation", (nchg >= 8) ? 1 : 0, 1);
        check("twocol_pulses", accept_count - base, 0);
        keys_down = 16'h0;
        repeat (24) @(negedge clk);
        #1;

        // Random presses
        for (int n = 0; n < 12; n++) begin
            press_key(4'($urandom_range(0, 15)), $urandom_range(0, 30), 0);
            repeat ($urandom_range(0, 8)) @(negedge clk);
            #1;
        end

        // 6. Reset while held, key re-detected afterwards
        kk = 4'($urandom_range(0, 15));
        push_exp(kk, 0);
        keys_down[kk] = 1'b1;
        wait_accept();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst2_row",   {28'h0, o_row},   32'he);
        check("rst2_data",  o_data,           32'h0);
        check("rst2_valid", {31'h0, o_key_valid}, 32'h0);
        check("rst2_key",   {28'h0, o_key},   32'h0);
        reset = 1'b0;
        model_data = 32'h0;
        push_exp(kk, 0);
        wait_accept();
        repeat (10) @(negedge clk);
        #1;
        keys_down = 16'h0;
        repeat (24) @(negedge clk);
        #1;

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
